pc_stall_ctrl: RTL and testbench
================================

PC_STALL_CTRL -- requirements
Module: pc_stall_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 Parameter EX_STALL, default 2, stall cycles for a RAW hazard on the EX-stage destination.
REQ-003 Parameter MEM_STALL, default 1, stall cycles for a RAW hazard on the MEM-stage destination.
REQ-004 The ports SHALL be:
- clk  in  1  clock, rising edge; the only clock in the block.
- rst  in  1  asynchronous, active-high reset.
- cur_pc  in  32  registered PC from the fetch stage.
- if_valid  in  1  fetch-stage PC valid.
- id_rs, id_rt  in  5 each  ID source registers.
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
- ex_wreg, mem_wreg  in  1 each  EX / MEM instruction writes a register.
- ex_rd, mem_rd  in  5 each  EX / MEM destination registers.
- br_taken  in  1  branch resolved taken in ID.
- br_target  in  32  branch target.
- jmp  in  1  jump in ID.
- jmp_target  in  32  jump target.
- next_pc  out  32  next PC to the fetch stage.
- pc_en  out  1  fetch-stage PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID insert NOP.
- idex_bubble  out  1  ID/EX insert NOP.
- stall_count  out  16  performance counter of stall cycles.

Function
REQ-005 The FSM SHALL have three states: BOOT, RUN and STALL.
REQ-006 BOOT SHALL last exactly one cycle after reset release, with next_pc=RESET_PC, pc_en=1, ifid_flush=1, ifid_en=1 and idex_bubble=0; the next state SHALL be RUN.
REQ-007 In RUN, a hazard SHALL be decoded as follows:
- exh = ex_wreg & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- memh is the same decode using mem_wreg and mem_rd.
- A hazard is only valid when if_valid=1.
REQ-008 In RUN with exh=1, the block SHALL go to STALL and load the stall counter with EX_STALL-1; with exh=0 and memh=1, it SHALL load MEM_STALL-1; exh SHALL win when both are set.
REQ-009 In the detecting cycle and in every STALL cycle, pc_en=0, ifid_en=0, idex_bubble=1 and ifid_flush=0; next_pc SHALL hold cur_pc.
REQ-010 In STALL, the counter SHALL decrement each cycle, and the block SHALL return to RUN in the cycle after the counter reads 0.
REQ-011 Hazard inputs SHALL be ignored while in STALL.
REQ-012 A stall of N cycles SHALL freeze the PC for exactly N cycles.
REQ-013 In RUN with no hazard, next_pc SHALL be chosen as follows:
- jmp=1: next_pc=jmp_target, ifid_flush=1.
- Else br_taken=1: next_pc=br_target, ifid_flush=1.
- Else: next_pc=cur_pc+4, with wrap-around modulo 2^32 and no flag.
- In all three cases pc_en=1, ifid_en=1 and idex_bubble=0.
REQ-014 A hazard SHALL take priority over jmp and br_taken in the same cycle; the redirect SHALL be re-evaluated on return to RUN.
REQ-015 jmp SHALL take priority over br_taken.
REQ-016 ifid_flush SHALL be asserted for one cycle per redirect only.
REQ-017 With if_valid=0 in RUN, the block SHALL behave as "no hazard" and still redirect on jmp or br_taken.
REQ-018 stall_count SHALL increment once per cycle with pc_en=0 outside BOOT and SHALL saturate at 16'hFFFF.
REQ-019 All outputs other than stall_count SHALL be combinational from the state and the inputs; the state, stall counter and stall_count SHALL be registered on the rising edge of clk.
REQ-020 An EX_STALL or MEM_STALL value of 0 SHALL behave as 1.

Reset
REQ-021 rst=1 SHALL asynchronously force the state to BOOT, the stall counter to 0 and stall_count to 0, regardless of clk.
REQ-022 While rst=1, the outputs SHALL be next_pc=RESET_PC, pc_en=1, ifid_en=1, ifid_flush=1 and idex_bubble=0.
REQ-023 Reset asserted mid-STALL SHALL abandon the stall immediately; after release, the block SHALL go through BOOT before RUN.

Verification
REQ-024 Reset and boot: release rst -> exactly one cycle with next_pc=0 and ifid_flush=1, then sequential cur_pc+4 with pc_en=1 every cycle.
REQ-025 EX hazard: ex_wreg=1, ex_rd=5, id_rs=5, id_use_rs=1, cur_pc=0x40 -> pc_en=0 and idex_bubble=1 for 2 cycles, next_pc=0x40, stall_count=2, then next_pc=0x44.
REQ-026 MEM hazard with ex_rd=0 and mem_rd=7=id_rt, id_use_rt=1 -> 1-cycle stall; a hazard on r0 (ex_rd=0, id_rs=0) -> no stall.
REQ-027 Simultaneous exh and br_taken (br_target=0x100) -> 2-cycle stall first, then next_pc=0x100 with ifid_flush=1 for one cycle; jmp and br_taken together -> jmp_target wins.
REQ-028 Boundary cases:
- cur_pc=32'hFFFFFFFC with no event -> next_pc=0.
- Force stall_count to 16'hFFFF, then stall -> stall_count remains 16'hFFFF.
- rst pulse asynchronously mid-stall -> outputs switch to their reset values within the same cycle.

Source files
------------

// File: rtl/pc_stall_ctrl.sv
// PC select and RAW-hazard stall controller: boots to RESET_PC, freezes fetch on EX/MEM
// hazards for a fixed number of cycles, otherwise steps/redirects the PC. Outputs are combinational.
module pc_stall_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter int          EX_STALL  = 2,
   parameter int          MEM_STALL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cur_pc,
   input  logic        if_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        ex_wreg,
   input  logic        mem_wreg,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  mem_rd,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   output logic [31:0] next_pc,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic [15:0] stall_count
);

   typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

   // A zero stall length is treated as one; lengths are expected to fit the 8-bit counter.
   localparam int          EX_N   = (EX_STALL  < 1) ? 1 : EX_STALL;
   localparam int          MEM_N  = (MEM_STALL < 1) ? 1 : MEM_STALL;
   localparam logic [7:0]  EX_LD  = 8'(EX_N - 1);
   localparam logic [7:0]  MEM_LD = 8'(MEM_N - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       exh, memh, hz;
   logic [7:0] ld;

   assign exh  = ex_wreg && (ex_rd != 5'd0) &&
                 ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
   assign memh = mem_wreg && (mem_rd != 5'd0) &&
                 ((id_use_rs && (id_rs == mem_rd)) || (id_use_rt && (id_rt == mem_rd)));
   assign hz   = if_valid && (exh || memh);
   assign ld   = exh ? EX_LD : MEM_LD;

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      next_pc     = cur_pc + 32'd4;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      case (state)
         BOOT: begin
            next_pc    = RESET_PC;
            ifid_flush = 1'b1;
            state_nx   = RUN;
         end
         RUN: begin
            if (hz) begin
               next_pc     = cur_pc;
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
               // The detecting cycle is the first frozen cycle; a 1-cycle stall needs no STALL state.
               if (ld != 8'd0) begin
                  state_nx = STALL;
                  cnt_nx   = ld;
               end
            end else if (jmp) begin
               next_pc    = jmp_target;
               ifid_flush = 1'b1;
            end else if (br_taken) begin
               next_pc    = br_target;
               ifid_flush = 1'b1;
            end
         end
         STALL: begin
            next_pc     = cur_pc;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            cnt_nx      = cnt - 8'd1;
            if (cnt <= 8'd1) state_nx = RUN;
         end
         default: state_nx = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BOOT;
         cnt         <= 8'd0;
         stall_count <= 16'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state != BOOT && !pc_en && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Scoreboard bench for pc_stall_ctrl: driver pushes hand-computed expectations, negedge monitor checks.
module tb_pc_stall_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic        pc_en;
      logic        ifid_en;
      logic        flush;
      logic        bub;
      logic [15:0] sc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cur_pc = '0;
   logic        if_valid = 1'b1;
   logic [4:0]  id_rs = '0, id_rt = '0;
   logic        id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic        ex_wreg = 1'b0, mem_wreg = 1'b0;
   logic [4:0]  ex_rd = '0, mem_rd = '0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        jmp = 1'b0;
   logic [31:0] jmp_target = '0;
   logic [31:0] next_pc;
   logic        pc_en, ifid_en, ifid_flush, idex_bubble;
   logic [15:0] stall_count;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   always #5 clk = ~clk;

   pc_stall_ctrl dut (
      .clk(clk), .rst(rst), .cur_pc(cur_pc), .if_valid(if_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .ex_rd(ex_rd), .mem_rd(mem_rd),
      .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
      .next_pc(next_pc), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .stall_count(stall_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic [31:0] pc, input logic en,
                             input logic ien, input logic fl, input logic bub,
                             input logic [15:0] sc);
      exp_t e;
      e = '{pc: pc, pc_en: en, ifid_en: ien, flush: fl, bub: bub, sc: sc};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic clear_in();
      if_valid = 1'b1; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      ex_wreg = 1'b0; mem_wreg = 1'b0; ex_rd = '0; mem_rd = '0;
      br_taken = 1'b0; br_target = '0; jmp = 1'b0; jmp_target = '0;
   endtask

   task automatic ex_hazard();
      ex_wreg = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
   endtask

   // Monitor: the DUT presents a new output set every cycle; compare whenever one is expected.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = '{pc: next_pc, pc_en: pc_en, ifid_en: ifid_en, flush: ifid_flush,
                bub: idex_bubble, sc: stall_count};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got pc=%h en=%b ifid_en=%b flush=%b bub=%b sc=%h, want pc=%h en=%b ifid_en=%b flush=%b bub=%b sc=%h",
                     nm, a.pc, a.pc_en, a.ifid_en, a.flush, a.bub, a.sc,
                     e.pc, e.pc_en, e.ifid_en, e.flush, e.bub, e.sc);
         end
      end
   end

   initial begin
      clear_in();
      tick(); cur_pc = 32'h0;
      expect_out("reset_held", 32'h0, 1, 1, 1, 0, 16'd0);
      tick(); rst = 1'b0;
      expect_out("boot", 32'h0, 1, 1, 1, 0, 16'd0);
      tick(); expect_out("run_seq0", 32'h4, 1, 1, 0, 0, 16'd0);
      tick(); cur_pc = 32'h4;
      expect_out("run_seq1", 32'h8, 1, 1, 0, 0, 16'd0);

      // EX hazard: two frozen cycles, hazard inputs still present in STALL
      tick(); cur_pc = 32'h40; ex_hazard();
      expect_out("ex_detect", 32'h40, 0, 0, 0, 1, 16'd0);
      tick(); expect_out("ex_stall", 32'h40, 0, 0, 0, 1, 16'd1);
      tick(); clear_in();
      expect_out("ex_resume", 32'h44, 1, 1, 0, 0, 16'd2);

      // MEM hazard on rt with ex_rd=0, then r0 hazard produces no stall
      tick(); cur_pc = 32'h44; ex_wreg = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
      mem_wreg = 1'b1; mem_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
      expect_out("mem_detect", 32'h44, 0, 0, 0, 1, 16'd2);
      tick(); mem_wreg = 1'b0;
      expect_out("r0_no_stall", 32'h48, 1, 1, 0, 0, 16'd3);
      tick(); cur_pc = 32'h48;
      expect_out("r0_no_stall2", 32'h4C, 1, 1, 0, 0, 16'd3);

      // Hazard beats branch; branch taken after the stall
      tick(); clear_in(); cur_pc = 32'h50; ex_hazard(); br_taken = 1'b1; br_target = 32'h100;
      expect_out("hz_br_detect", 32'h50, 0, 0, 0, 1, 16'd3);
      tick(); expect_out("hz_br_stall", 32'h50, 0, 0, 0, 1, 16'd4);
      tick(); ex_wreg = 1'b0;
      expect_out("br_redirect", 32'h100, 1, 1, 1, 0, 16'd5);
      tick(); br_taken = 1'b0; cur_pc = 32'h100;
      expect_out("br_flush_once", 32'h104, 1, 1, 0, 0, 16'd5);

      tick(); cur_pc = 32'h104; jmp = 1'b1; jmp_target = 32'h200; br_taken = 1'b1; br_target = 32'h300;
      expect_out("jmp_over_br", 32'h200, 1, 1, 1, 0, 16'd5);
      tick(); clear_in(); if_valid = 1'b0; ex_hazard(); jmp = 1'b1; jmp_target = 32'h280;
      expect_out("ifv0_jmp", 32'h280, 1, 1, 1, 0, 16'd5);
      tick(); clear_in(); cur_pc = 32'hFFFF_FFFC;
      expect_out("pc_wrap", 32'h0, 1, 1, 0, 0, 16'd5);

      // Asynchronous reset in the middle of a stall
      tick(); cur_pc = 32'h60; ex_hazard();
      expect_out("pre_rst_detect", 32'h60, 0, 0, 0, 1, 16'd5);
      tick(); rst = 1'b1;
      expect_out("rst_mid_stall", 32'h0, 1, 1, 1, 0, 16'd0);
      tick(); rst = 1'b0; clear_in(); cur_pc = 32'h0;
      expect_out("reboot", 32'h0, 1, 1, 1, 0, 16'd0);
      tick(); expect_out("rerun", 32'h4, 1, 1, 0, 0, 16'd0);

      // Saturation: a held 1-cycle MEM hazard stalls every cycle
      tick(); cur_pc = 32'h80; mem_wreg = 1'b1; mem_rd = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
      for (int i = 0; i < 65540; i++) tick();
      expect_out("sat_ffff", 32'h80, 0, 0, 0, 1, 16'hFFFF);
      tick(); expect_out("sat_hold", 32'h80, 0, 0, 0, 1, 16'hFFFF);

      tick(); tick();
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
